lockstep_fifo_bank: RTL and testbench
=====================================

# lockstep_fifo_bank

Parametrised N-channel FIFO bank with a single shared write/read handshake, so all channels advance in lockstep (e.g. I/Q at the demodulator input, left/right audio at the output). Replaces per-channel FIFO pairs whose full/empty flags consumers must AND together. Adds occupancy count, almost-full/almost-empty flags, a selectable first-word-fall-through (FWFT) or registered read mode, and sticky overflow/underflow error flags.

## Interface
- DATA_WIDTH, 32, bits per channel word
- NUM_CH, 2, number of lockstepped channels (≥1)
- DEPTH, 16, entries per channel; power of two, ≥4
- AFULL_LVL, DEPTH-2, almost_full asserts when count ≥ AFULL_LVL
- AEMPTY_LVL, 2, almost_empty asserts when count ≤ AEMPTY_LVL
- FWFT, 1, 1 = head word visible on dout while !empty; 0 = dout registered on accepted read
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- wr_en  in  1  write request, all channels
- din  in  NUM_CH*DATA_WIDTH  channel c at bits [c*DATA_WIDTH +: DATA_WIDTH]
- full  out  1  count == DEPTH
- almost_full  out  1  count ≥ AFULL_LVL
- rd_en  in  1  read request, all channels
- dout  out  NUM_CH*DATA_WIDTH  same packing as din
- empty  out  1  count == 0
- almost_empty  out  1  count ≤ AEMPTY_LVL
- count  out  $clog2(DEPTH)+1  current occupancy
- ovf_err  out  1  sticky: write attempted while full
- unf_err  out  1  sticky: read attempted while empty
- err_clr  in  1  synchronous clear of both sticky flags

## Operation
- Shared write pointer wptr and read pointer rptr, each $clog2(DEPTH) bits, wrap modulo DEPTH; count held as a separate register.
- Write accepted iff wr_en && !full; stores the full din vector at wptr, wptr increments.
- Read accepted iff rd_en && !empty; rptr increments.
- Simultaneous accepted write and read: count unchanged; both pointers advance.
- Write while full: data dropped, no state change except ovf_err ← 1. This holds even if rd_en is also high that cycle (full gates the write; no pass-through).
- Read while empty: ignored, unf_err ← 1; dout does not change.
- err_clr clears the sticky flags; a new error in the same cycle wins (flag stays 1).
- FWFT=1: dout = mem[rptr] combinationally from storage; value is don't-care while empty, and the bench must not check it.
- FWFT=0: dout register loads mem[rptr] on an accepted read; it holds otherwise.
- Flags full, empty, almost_* are decoded from the registered count, so they are glitch-free.

## Timing
- Reset (async assert, sync release): wptr=rptr=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, ovf_err=unf_err=0, dout=0.
- Write-to-empty-deassert: 1 cycle. After the edge that accepts the first write, empty=0.
- FWFT=1 read latency: 0. The word is on dout in the same cycle rd_en is presented, and the next word appears after that edge.
- FWFT=0 read latency: 1. The word appears on dout after the edge that accepts rd_en.
- Full asserts after the edge that accepts write number DEPTH. It deasserts after the first accepted read.
- Reset mid-stream discards all contents. The first write after reset lands at address 0.

## Structure
- Shared package fm_radio_pkg holds the default constants (FIFO_DEPTH, AUDIO_WIDTH, IQ_CHANNELS) and a typedef for the per-channel data word.
- One sub-module, lockstep_fifo_ram: a DEPTH × (NUM_CH*DATA_WIDTH) storage array with one synchronous write port and one asynchronous read port. It is used directly in FWFT=1 and registered in the parent in FWFT=0.
- Pointer, count, flag and error logic live in lockstep_fifo_bank.

## Test plan
Bench uses NUM_CH=2, DATA_WIDTH=32, DEPTH=8, AFULL_LVL=6, AEMPTY_LVL=2.
- Fill/drain, FWFT=1: write 8 words {0x1000_000k, 0x2000_000k} for k=0..7. Required: full=1, count=8, almost_full high from count 6. Then read 8. Required: dout order k=0..7, with each word present in the same cycle as rd_en. End state empty=1, count=0.
- Registered mode, FWFT=0: write 3 words, then read 3. Required: each word appears 1 cycle after its rd_en. dout holds the last word after the final read.
- Overflow: with count=8, assert wr_en and rd_en together with din=0xDEAD_BEEF pair. Required: the read succeeds, count=7, ovf_err=1, and 0xDEAD_BEEF is never read out. err_clr then gives ovf_err=0.
- Underflow: rd_en while empty. Required: unf_err=1, count stays 0. err_clr plus a fresh underflow in the same cycle leaves unf_err=1.
- Wrap-around: run 20 words of continuous simultaneous write/read at count 3. Required: pointers wrap past address 7, count stays 3, and the output sequence matches the input exactly.
- Reset mid-stream: assert reset asynchronously mid-cycle at count 5. Required: outputs take their reset values immediately. After release, a write of 0x0000_0042 pair is the first word read.

Source files
------------

// File: rtl/fm_radio_pkg.sv
// Shared constants for the FM radio datapath.
//   FIFO_DEPTH  : default entries per lockstep FIFO channel
//   AUDIO_WIDTH : default bits per channel sample
//   IQ_CHANNELS : default number of lockstepped channels (I and Q)
//   sample_t    : one per-channel data word
package fm_radio_pkg;

    localparam int unsigned FIFO_DEPTH  = 16;
    localparam int unsigned AUDIO_WIDTH = 32;
    localparam int unsigned IQ_CHANNELS = 2;

    typedef logic [AUDIO_WIDTH-1:0] sample_t;

endpackage

// File: rtl/lockstep_fifo_ram.sv
// Storage array for the lockstep FIFO bank: one synchronous write port and
// one asynchronous read port, every channel held side by side in one row.
//   clk     : write clock, rising edge
//   wr_en   : write strobe
//   wr_addr : write row
//   wr_data : full packed channel vector
//   rd_addr : read row
//   rd_data : combinational contents of rd_addr
module lockstep_fifo_ram #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // No reset on the array: contents are only visible through valid pointers.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/lockstep_fifo_bank.sv
// N-channel FIFO bank sharing one write/read handshake so all channels
// advance together.
//   clk, reset              : clock and asynchronous active-high reset
//   wr_en, din              : write request and packed channel words
//   full, almost_full       : count == DEPTH, count >= AFULL_LVL
//   rd_en, dout             : read request and packed head words
//   empty, almost_empty     : count == 0, count <= AEMPTY_LVL
//   count                   : current occupancy
//   ovf_err, unf_err        : sticky write-while-full / read-while-empty
//   err_clr                 : synchronous clear of both sticky flags
module lockstep_fifo_bank
    import fm_radio_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = AUDIO_WIDTH,
    parameter int unsigned NUM_CH     = IQ_CHANNELS,
    parameter int unsigned DEPTH      = FIFO_DEPTH,
    parameter int unsigned AFULL_LVL  = DEPTH - 2,
    parameter int unsigned AEMPTY_LVL = 2,
    parameter bit          FWFT       = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [NUM_CH*DATA_WIDTH-1:0] din,
    output logic                         full,
    output logic                         almost_full,
    input  logic                         rd_en,
    output logic [NUM_CH*DATA_WIDTH-1:0] dout,
    output logic                         empty,
    output logic                         almost_empty,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         ovf_err,
    output logic                         unf_err,
    input  logic                         err_clr
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned W  = NUM_CH * DATA_WIDTH;

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_LVL);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_LVL);

    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q;
    logic          ovf_q, unf_q;
    logic          wr_ok, rd_ok;
    logic [W-1:0]  ram_rd_data;

    // Flags decode straight from the count register.
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AFULL_C);
    assign almost_empty = (count_q <= AEMPTY_C);
    assign count        = count_q;
    assign ovf_err      = ovf_q;
    assign unf_err      = unf_q;

    // Full gates the write even when a read frees a slot the same cycle.
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            if (wr_ok) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (rd_ok) begin
                rptr_q <= rptr_q + AW'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            // A fresh error outranks a clear in the same cycle.
            ovf_q <= (ovf_q && !err_clr) || (wr_en && full);
            unf_q <= (unf_q && !err_clr) || (rd_en && empty);
        end
    end

    lockstep_fifo_ram #(
        .DEPTH (DEPTH),
        .WIDTH (W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_ok),
        .wr_addr (wptr_q),
        .wr_data (din),
        .rd_addr (rptr_q),
        .rd_data (ram_rd_data)
    );

    if (FWFT) begin : g_fwft
        assign dout = ram_rd_data;
    end else begin : g_reg
        logic [W-1:0] dout_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                dout_q <= '0;
            end else if (rd_ok) begin
                dout_q <= ram_rd_data;
            end
        end

        assign dout = dout_q;
    end

endmodule

// File: tb/tb_lockstep_fifo_bank.sv
// Directed bench: one FWFT instance and one registered-read instance.
module tb_lockstep_fifo_bank;

    localparam int unsigned DW = 32;
    localparam int unsigned NC = 2;
    localparam int unsigned DP = 8;

    logic          clk = 1'b0;
    logic          reset;

    logic          wr_en_f, rd_en_f, err_clr_f;
    logic [63:0]   din_f, dout_f;
    logic          full_f, afull_f, empty_f, aempty_f, ovf_f, unf_f;
    logic [3:0]    count_f;

    logic          wr_en_r, rd_en_r, err_clr_r;
    logic [63:0]   din_r, dout_r;
    logic          full_r, afull_r, empty_r, aempty_r, ovf_r, unf_r;
    logic [3:0]    count_r;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    lockstep_fifo_bank #(
        .DATA_WIDTH (DW), .NUM_CH (NC), .DEPTH (DP),
        .AFULL_LVL (6), .AEMPTY_LVL (2), .FWFT (1'b1)
    ) u_dut_fwft (
        .clk (clk), .reset (reset),
        .wr_en (wr_en_f), .din (din_f), .full (full_f), .almost_full (afull_f),
        .rd_en (rd_en_f), .dout (dout_f), .empty (empty_f), .almost_empty (aempty_f),
        .count (count_f), .ovf_err (ovf_f), .unf_err (unf_f), .err_clr (err_clr_f)
    );

    lockstep_fifo_bank #(
        .DATA_WIDTH (DW), .NUM_CH (NC), .DEPTH (DP),
        .AFULL_LVL (6), .AEMPTY_LVL (2), .FWFT (1'b0)
    ) u_dut_reg (
        .clk (clk), .reset (reset),
        .wr_en (wr_en_r), .din (din_r), .full (full_r), .almost_full (afull_r),
        .rd_en (rd_en_r), .dout (dout_r), .empty (empty_r), .almost_empty (aempty_r),
        .count (count_r), .ovf_err (ovf_r), .unf_err (unf_r), .err_clr (err_clr_r)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Channel 0 in the low half, channel 1 in the high half.
    function automatic logic [63:0] wf(input int k);
        return {32'h2000_0000 + 32'(k), 32'h1000_0000 + 32'(k)};
    endfunction

    function automatic logic [63:0] ww(input int k);
        return {32'h5000_0000 + 32'(k), 32'h4000_0000 + 32'(k)};
    endfunction

    function automatic logic [63:0] wr3(input int k);
        return {32'h7000_0000 + 32'(k), 32'h6000_0000 + 32'(k)};
    endfunction

    initial begin
        reset   = 1'b1;
        wr_en_f = 1'b0; rd_en_f = 1'b0; err_clr_f = 1'b0; din_f = '0;
        wr_en_r = 1'b0; rd_en_r = 1'b0; err_clr_r = 1'b0; din_r = '0;
        #12 reset = 1'b0;
        step();

        // Reset state
        check("rst_count", 64'(count_f), 64'd0);
        check("rst_empty", 64'(empty_f), 64'd1);
        check("rst_aempty", 64'(aempty_f), 64'd1);
        check("rst_full", 64'(full_f), 64'd0);
        check("rst_afull", 64'(afull_f), 64'd0);
        check("rst_ovf", 64'(ovf_f), 64'd0);
        check("rst_unf", 64'(unf_f), 64'd0);
        check("rst_dout_reg", dout_r, 64'd0);

        // Fill FWFT instance to DEPTH
        for (int k = 0; k < 8; k++) begin
            din_f   = wf(k);
            wr_en_f = 1'b1;
            step();
            check("fill_count", 64'(count_f), 64'(k + 1));
            check("fill_afull", 64'(afull_f), 64'((k + 1) >= 6));
            check("fill_full", 64'(full_f), 64'((k + 1) == 8));
            check("fill_empty", 64'(empty_f), 64'd0);
        end
        wr_en_f = 1'b0;

        // Overflow with simultaneous read: read pops word 0, write dropped
        din_f   = 64'hDEAD_BEEF_DEAD_BEEF;
        wr_en_f = 1'b1;
        rd_en_f = 1'b1;
        #1 check("ovf_rd_dout", dout_f, wf(0));
        step();
        wr_en_f = 1'b0;
        rd_en_f = 1'b0;
        check("ovf_count", 64'(count_f), 64'd7);
        check("ovf_flag", 64'(ovf_f), 64'd1);
        check("ovf_full_clr", 64'(full_f), 64'd0);
        err_clr_f = 1'b1;
        step();
        err_clr_f = 1'b0;
        check("ovf_cleared", 64'(ovf_f), 64'd0);

        // Drain the rest; the dropped word must never appear
        for (int k = 1; k < 8; k++) begin
            rd_en_f = 1'b1;
            #1 check("drain_dout", dout_f, wf(k));
            step();
            check("drain_count", 64'(count_f), 64'(7 - k));
        end
        rd_en_f = 1'b0;
        check("drain_empty", 64'(empty_f), 64'd1);
        check("drain_aempty", 64'(aempty_f), 64'd1);

        // Underflow, then clear colliding with a fresh underflow
        rd_en_f = 1'b1;
        step();
        check("unf_flag", 64'(unf_f), 64'd1);
        check("unf_count", 64'(count_f), 64'd0);
        err_clr_f = 1'b1;
        step();
        check("unf_clr_collide", 64'(unf_f), 64'd1);
        rd_en_f = 1'b0;
        step();
        err_clr_f = 1'b0;
        check("unf_clr_plain", 64'(unf_f), 64'd0);
        check("unf_no_ovf", 64'(ovf_f), 64'd0);

        // Wrap-around: preload 3, then 20 simultaneous write/read cycles
        for (int k = 0; k < 3; k++) begin
            din_f   = ww(k);
            wr_en_f = 1'b1;
            step();
        end
        check("wrap_pre_count", 64'(count_f), 64'd3);
        check("wrap_pre_aempty", 64'(aempty_f), 64'd0);
        for (int i = 0; i < 20; i++) begin
            din_f   = ww(i + 3);
            rd_en_f = 1'b1;
            #1 check("wrap_dout", dout_f, ww(i));
            step();
            check("wrap_count", 64'(count_f), 64'd3);
        end
        wr_en_f = 1'b0;
        for (int i = 20; i < 23; i++) begin
            #1 check("wrap_tail", dout_f, ww(i));
            step();
        end
        rd_en_f = 1'b0;
        check("wrap_empty", 64'(empty_f), 64'd1);

        // Registered mode: 1-cycle read latency, hold after last read
        for (int k = 0; k < 3; k++) begin
            din_r   = wr3(k);
            wr_en_r = 1'b1;
            step();
        end
        wr_en_r = 1'b0;
        check("reg_count", 64'(count_r), 64'd3);
        check("reg_dout_before", dout_r, 64'd0);
        for (int k = 0; k < 3; k++) begin
            rd_en_r = 1'b1;
            #1 check("reg_no_early", dout_r, (k == 0) ? 64'd0 : wr3(k - 1));
            step();
            rd_en_r = 1'b0;
            check("reg_dout", dout_r, wr3(k));
        end
        step();
        step();
        check("reg_hold", dout_r, wr3(2));
        rd_en_r = 1'b1;
        step();
        rd_en_r = 1'b0;
        check("reg_unf_hold", dout_r, wr3(2));
        check("reg_unf_flag", 64'(unf_r), 64'd1);

        // Reset mid-stream at count 5
        for (int k = 0; k < 5; k++) begin
            din_r   = wr3(10 + k);
            wr_en_r = 1'b1;
            step();
        end
        wr_en_r = 1'b0;
        check("mid_count", 64'(count_r), 64'd5);
        #2 reset = 1'b1;
        #1;
        check("arst_count", 64'(count_r), 64'd0);
        check("arst_empty", 64'(empty_r), 64'd1);
        check("arst_aempty", 64'(aempty_r), 64'd1);
        check("arst_dout", dout_r, 64'd0);
        check("arst_unf", 64'(unf_r), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        step();
        din_r   = {32'h0000_0042, 32'h0000_0042};
        wr_en_r = 1'b1;
        step();
        wr_en_r = 1'b0;
        check("post_rst_count", 64'(count_r), 64'd1);
        rd_en_r = 1'b1;
        step();
        rd_en_r = 1'b0;
        check("post_rst_dout", dout_r, {32'h0000_0042, 32'h0000_0042});
        check("post_rst_empty", 64'(empty_r), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
